// File: rtl/axi4_fb_pkg.sv
// Shared encodings, FSM state type and burst-legality helper for the frame-buffer read slave.
package axi4_fb_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // ST_INIT holds arready low for the first clock after reset release.
  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_DATA
  } state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats; other burst types accept any length.
  function automatic logic burst_len_ok(input logic [1:0] burst, input logic [7:0] len);
    if (burst != BURST_WRAP) return 1'b1;
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_fb_addr_gen.sv
// Combinational burst address walker (FIXED/INCR/WRAP) and array range decode.
module axi4_fb_addr_gen
  import axi4_fb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 64,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned IDX_W     = 12,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic [AW-1:0]    addr,
  input  logic [2:0]       size,
  input  logic [7:0]       len,
  input  logic [1:0]       burst,
  input  logic [AW-1:0]    chk_addr,
  output logic [AW-1:0]    next_addr,
  output logic             in_range,
  output logic [IDX_W-1:0] word_idx
);

  localparam int unsigned LSB = $clog2(DW / 8);

  logic [AW-1:0] beat_bytes;
  logic [AW-1:0] aligned;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] offset;
  logic [AW-1:0] word_off;

  // Next beat address; WRAP keeps the upper bits of the window and wraps the low bits.
  always_comb begin
    beat_bytes = AW'(1) << size;
    aligned    = addr & ~(beat_bytes - AW'(1));
    incr_addr  = aligned + beat_bytes;
    wrap_mask  = (AW'({1'b0, len} + 9'd1) << size) - AW'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  // Range check in word units so the span never overflows the address width.
  always_comb begin
    offset   = chk_addr - BASE_ADDR;
    word_off = offset >> LSB;
    in_range = (word_off < AW'(MEM_DEPTH));
    word_idx = word_off[IDX_W-1:0];
  end

endmodule

// File: rtl/axi4_fb_rd_slave.sv
// AXI4 read-only frame-buffer responder: one outstanding burst, backdoor-loaded word array.
module axi4_fb_rd_slave
  import axi4_fb_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH      = 4096,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [AXI_ID_WIDTH-1:0]       arid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     araddr_i,
  input  logic [7:0]                    arlen_i,
  input  logic [2:0]                    arsize_i,
  input  logic [1:0]                    arburst_i,
  input  logic                          arvalid_i,
  output logic                          arready_o,
  output logic [AXI_ID_WIDTH-1:0]       rid_o,
  output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
  output logic [1:0]                    rresp_o,
  output logic                          rlast_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  input  logic                          mem_we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0]  mem_waddr_i,
  input  logic [AXI_DATA_WIDTH-1:0]     mem_wdata_i,
  output logic [31:0]                   rd_beats_o
);

  localparam int unsigned LSB   = $clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  state_t state, state_nxt;
  logic   ld_first, ld_next, hs;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [7:0]                cnt_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      err_q;

  logic                      ar_err, beat_err;
  logic [AXI_ADDR_WIDTH-1:0] next_addr, chk_addr;
  logic                      in_range;
  logic [IDX_W-1:0]          word_idx;
  logic [1:0]                beat_resp;
  logic [AXI_DATA_WIDTH-1:0] beat_data;

  axi4_fb_addr_gen #(
    .AW        (AXI_ADDR_WIDTH),
    .DW        (AXI_DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .chk_addr  (chk_addr),
    .next_addr (next_addr),
    .in_range  (in_range),
    .word_idx  (word_idx)
  );

  // State register; reset parks in ST_INIT so arready rises one clock after release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Next-state and beat-load strobes.
  always_comb begin
    state_nxt = state;
    ld_first  = 1'b0;
    ld_next   = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_IDLE;
      ST_IDLE: if (arvalid_i) begin
        ld_first  = 1'b1;
        state_nxt = ST_DATA;
      end
      ST_DATA: if (rvalid_o && rready_i) begin
        if (rlast_o) state_nxt = ST_IDLE;
        else         ld_next   = 1'b1;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign arready_o = (state == ST_IDLE);
  assign hs        = rvalid_o && rready_i;

  // Beat payload: the first beat decodes the AR address, later beats the walked address.
  always_comb begin
    ar_err    = (arburst_i == BURST_RSVD) || (arsize_i > 3'(LSB)) ||
                !burst_len_ok(arburst_i, arlen_i);
    beat_err  = ld_first ? ar_err : err_q;
    chk_addr  = ld_first ? araddr_i : next_addr;
    beat_resp = beat_err ? RESP_SLVERR : (in_range ? RESP_OKAY : RESP_DECERR);
    beat_data = (!beat_err && in_range) ? mem[word_idx] : '0;
  end

  // Backdoor preload port; the array is never reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_i) mem[mem_waddr_i] <= mem_wdata_i;
  end

  // Burst context captured at AR accept and advanced per accepted non-last beat.
  always_ff @(posedge clk_i) begin
    if (ld_first) begin
      addr_q  <= araddr_i;
      len_q   <= arlen_i;
      size_q  <= arsize_i;
      burst_q <= arburst_i;
      err_q   <= ar_err;
      cnt_q   <= 8'd0;
    end else if (ld_next) begin
      addr_q  <= next_addr;
      cnt_q   <= cnt_q + 8'd1;
    end
  end

  // R channel register and accepted-beat counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o   <= 1'b0;
      rlast_o    <= 1'b0;
      rdata_o    <= '0;
      rresp_o    <= RESP_OKAY;
      rid_o      <= '0;
      rd_beats_o <= 32'd0;
    end else begin
      if (ld_first || ld_next) begin
        rvalid_o <= 1'b1;
        rdata_o  <= beat_data;
        rresp_o  <= beat_resp;
        rlast_o  <= ld_first ? (arlen_i == 8'd0) : ((cnt_q + 8'd1) == len_q);
      end else if (hs) begin
        rvalid_o <= 1'b0;
        rlast_o  <= 1'b0;
      end
      if (ld_first) rid_o <= arid_i;
      if (hs) rd_beats_o <= rd_beats_o + 32'd1;
    end
  end

endmodule

// File: doc/axi4_fb_rd_slave.md
# axi4_fb_rd_slave

AXI4 read-only responder that models the frame-buffer memory on the far side of `axi4_vga`'s AXI4 read master. It accepts AR bursts, walks the burst address (FIXED/INCR/WRAP), and returns R beats from an internal word array. A backdoor write port preloads pixel data, so the bench can drive real frames through the VGA path and check error responses.

## Interface
- `AXI_ADDR_WIDTH`, 32, byte address width
- `AXI_DATA_WIDTH`, 64, R data width; power of two, 32..256
- `AXI_ID_WIDTH`, 4, ID width
- `MEM_DEPTH`, 4096, number of `AXI_DATA_WIDTH` words
- `BASE_ADDR`, 32'h0, byte address of word 0; aligned to data width
---
- `clk_i` in 1: single clock
- `rst_i` in 1: reset, asynchronous, active-high
- `arid_i` in ID: read ID
- `araddr_i` in ADDR: burst start byte address
- `arlen_i` in 8: beats−1
- `arsize_i` in 3: log2 bytes per beat
- `arburst_i` in 2: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- `arvalid_i` in 1 / `arready_o` out 1: AR handshake
- `rid_o` out ID, `rdata_o` out DATA, `rresp_o` out 2, `rlast_o` out 1: R payload
- `rvalid_o` out 1 / `rready_i` in 1: R handshake
- `mem_we_i` in 1, `mem_waddr_i` in log2(MEM_DEPTH), `mem_wdata_i` in DATA: backdoor word write
- `rd_beats_o` out 32: count of accepted R beats, wraps at 2^32

## Operation
- FSM states:
  - IDLE: `arready_o`=1. On `arvalid_i`, latch ID, addr, len, size, burst; go to DATA.
  - DATA: `arready_o`=0. Present beats; return to IDLE when the `rlast_o` beat handshakes.
- One outstanding burst; no AR queue.
- Burst error flag is computed once at AR accept. It is set by any of:
  - `arburst_i`=3
  - `arsize_i` > log2(AXI_DATA_WIDTH/8)
  - WRAP with `arlen_i` not in {1,3,7,15}
- Flag set: every beat of the burst has `rresp_o`=SLVERR (2'b10) and `rdata_o`=0. Full arlen+1 beats are still returned.
- Per beat, address outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH·bytes) gives DECERR (2'b11), `rdata_o`=0. Otherwise OKAY with `mem[(addr−BASE_ADDR)>>log2(bytes)]`.
- SLVERR takes precedence over DECERR.
- Next beat address:
  - FIXED: unchanged.
  - INCR: aligned(addr)+2^size. No 4 KB boundary check; wraps modulo 2^ADDR.
  - WRAP: increment within a window of (len+1)·2^size bytes, aligned to that size.
- Narrow beats return the full word containing the address; the master selects lanes.
- Backdoor write commits at the clock edge. Array contents are not reset.

## Timing
- Reset values: `arready_o`=0, `rvalid_o`=0, `rlast_o`=0, `rdata_o`=0, `rresp_o`=0, `rid_o`=0, `rd_beats_o`=0. `arready_o` rises on the first clock after `rst_i` falls.
- AR handshake in cycle N: first beat valid in N+1 (1-cycle latency).
- Subsequent beats issue back-to-back, one per cycle while `rready_i`=1.
- R payload is held stable while `rvalid_o`=1 and `rready_i`=0.
- `rlast_o`=1 exactly on beat index arlen; arlen=0 gives a single beat with `rlast_o`=1.
- Last beat accepted in cycle M: `arready_o`=1 in M+1.
- Beat data is sampled from the array when the beat is loaded into the R register. A backdoor write to the same word on the same edge returns the old data.
- `rst_i` asserted mid-burst: R outputs clear immediately and the burst is dropped. No further beats after release.

## Structure
- Package `axi4_fb_pkg`:
  - burst encodings and resp encodings (OKAY/SLVERR/DECERR)
  - FSM state enum
  - function `burst_len_ok`
- Sub-module `axi4_fb_addr_gen`: combinational next-address (FIXED/INCR/WRAP) plus in-range check. The parent holds the FSM, registers, array and counter.

## Test plan
- Preload words 0..15 with `i`. INCR addr=BASE, len=7, size=3, `rready_i`=1. Expect 8 beats, data 0..7, OKAY, `rlast_o` only on beat 7, `rvalid_o` 1 cycle after AR, `rd_beats_o`=8.
- WRAP addr=BASE+0x28, len=3, size=3. Expect data 5,6,7,4 and `rlast_o` on the 4th beat.
- Random `rready_i` stalls on an INCR len=15 burst. Expect payload stable during stalls and data 0..15 in order; `arready_o` stays 0 until 1 cycle after the last beat.
- Three error bursts, each returning all beats with `rdata_o`=0:
  - `arburst_i`=3, len=2: 3 beats SLVERR.
  - WRAP len=2: 3 beats SLVERR.
  - INCR starting at last word, len=1: beat0 OKAY, beat1 DECERR.
- Assert `rst_i` during beat 3 of len=7. Expect `rvalid_o`=0 immediately, `rd_beats_o`=0, then a new burst served normally after release.
